// File: rtl/sha256_pkg.sv
// SHA-256 constants, FSM state type and the bitwise round/schedule helpers
// shared by the stream core and its round datapath.
package sha256_pkg;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_BLK, S_COMPUTE, S_FINAL} state_e;

  // Packed so index 0 is H0, matching the iv_in / result port layout.
  localparam logic [7:0][31:0] H_INIT = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] Sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] Sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round; st[0] = a .. st[7] = h.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [7:0][31:0] st_i,
  input  logic [31:0]      w_i,
  input  logic [31:0]      k_i,
  output logic [7:0][31:0] st_o
);

  logic [31:0] t1, t2;

  always_comb begin
    t1 = st_i[7] + Sigma1(st_i[4]) + ch(st_i[4], st_i[5], st_i[6]) + k_i + w_i;
    t2 = Sigma0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);
    st_o    = {st_i[6:0], t1 + t2};
    st_o[4] = st_i[3] + t1;
  end

endmodule

// File: rtl/sha256_stream_core.sv
// Multi-block SHA-256 engine: chains H across blocks, ROUNDS_PER_CYCLE rounds
// per COMPUTE cycle, pulses result_valid after the block flagged last.
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              iv_sel,
  input  logic [7:0][31:0]  iv_in,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [15:0][31:0] blk_data,
  input  logic              blk_last,
  output logic [7:0][31:0]  result,
  output logic              result_valid,
  output logic              busy
);

  localparam int R = ROUNDS_PER_CYCLE;

  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_param
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  state_e           state_q, state_d;
  logic [7:0][31:0] h_q, h_d, st_q, st_d, result_q, result_d;
  logic [15:0][31:0] w_q, w_d;
  logic             last_q, last_d, result_valid_q, result_valid_d;
  logic [6:0]       rnd_q, rnd_d;

  // wx[0..15] is the live window (wx[0] = W[rnd]); wx[16..] are the R new words.
  logic [15+R:0][31:0] wx;
  logic [7:0][31:0]    st_chain [R+1];
  logic [R-1:0][31:0]  k_r;

  always_comb begin
    wx = '0;
    wx[15:0] = w_q;
    for (int j = 0; j < R; j++)
      wx[16+j] = sigma1(wx[14+j]) + wx[9+j] + sigma0(wx[1+j]) + wx[j];
  end

  assign st_chain[0] = st_q;

  for (genvar j = 0; j < R; j++) begin : g_rnd
    assign k_r[j] = K[rnd_q[5:0] + 6'(j)];
    sha256_round u_round (
      .st_i (st_chain[j]),
      .w_i  (wx[j]),
      .k_i  (k_r[j]),
      .st_o (st_chain[j+1])
    );
  end

  always_comb begin
    state_d        = state_q;
    h_d            = h_q;
    st_d           = st_q;
    w_d            = w_q;
    last_d         = last_q;
    rnd_d          = rnd_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        h_d     = iv_sel ? iv_in : H_INIT;
        state_d = S_WAIT_BLK;
      end
      S_WAIT_BLK: if (blk_valid) begin
        w_d     = blk_data;
        st_d    = h_q;
        last_d  = blk_last;
        rnd_d   = '0;
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        st_d  = st_chain[R];
        w_d   = wx[R+15:R];
        rnd_d = rnd_q + 7'(R);
        if (rnd_q + 7'(R) == 7'd64) state_d = S_FINAL;
      end
      S_FINAL: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + st_q[i];
        if (last_q) begin
          result_d       = h_d;
          result_valid_d = 1'b1;
          state_d        = S_IDLE;
        end else begin
          state_d = S_WAIT_BLK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      h_q            <= '0;
      st_q           <= '0;
      w_q            <= '0;
      last_q         <= 1'b0;
      rnd_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      h_q            <= h_d;
      st_q           <= st_d;
      w_q            <= w_d;
      last_q         <= last_d;
      rnd_q          <= rnd_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign blk_ready    = (state_q == S_WAIT_BLK);
  assign busy         = (state_q != S_IDLE);
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_sha256_stream_core.sv
// Bench for sha256_stream_core at R = 1, 2, 4, 8: known-answer, midstate,
// backpressure, mid-compute reset and random multi-block messages.
module tb_sha256_stream_core;

  localparam int NI = 4;
  localparam int RS [NI] = '{1, 2, 4, 8};

  localparam logic [255:0] ABC_DIG = {
    32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
    32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
  localparam logic [255:0] NIST_DIG = {
    32'h19db06c1, 32'hf6ecedd4, 32'h64ff2167, 32'ha33ce459,
    32'h0c3e6039, 32'he5c02693, 32'hd20638b8, 32'h248d6a61};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_s     [NI];
  logic              start_s     [NI];
  logic              iv_sel_s    [NI];
  logic [7:0][31:0]  iv_in_s     [NI];
  logic              blk_valid_s [NI];
  logic              blk_ready_w [NI];
  logic [15:0][31:0] blk_data_s  [NI];
  logic              blk_last_s  [NI];
  logic [7:0][31:0]  result_w    [NI];
  logic              result_valid_w [NI];
  logic              busy_w      [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sha256_stream_core #(.ROUNDS_PER_CYCLE(RS[g])) u_dut (
      .clk          (clk),
      .reset        (reset_s[g]),
      .start        (start_s[g]),
      .iv_sel       (iv_sel_s[g]),
      .iv_in        (iv_in_s[g]),
      .blk_valid    (blk_valid_s[g]),
      .blk_ready    (blk_ready_w[g]),
      .blk_data     (blk_data_s[g]),
      .blk_last     (blk_last_s[g]),
      .result       (result_w[g]),
      .result_valid (result_valid_w[g]),
      .busy         (busy_w[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference constants derived from primes, independent of the RTL tables.
  logic [31:0]      kk [64];
  logic [7:0][31:0] hh0;

  function automatic logic [31:0] frac32(input real x);
    return 32'(longint'($floor((x - $floor(x)) * 4294967296.0)));
  endfunction

  task automatic build_constants();
    int p = 2, n = 0;
    while (n < 64) begin
      bit prime = 1'b1;
      for (int q = 2; q * q <= p; q++) if (p % q == 0) prime = 1'b0;
      if (prime) begin
        kk[n] = frac32($pow(real'(p), 1.0 / 3.0));
        if (n < 8) hh0[n] = frac32($sqrt(real'(p)));
        n++;
      end
      p++;
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook FIPS 180-4 compression with a full 64-word schedule.
  function automatic logic [7:0][31:0] ref_compress(input logic [7:0][31:0] h,
                                                    input logic [15:0][31:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    logic [7:0][31:0] o;
    for (int t = 0; t < 64; t++)
      if (t < 16) w[t] = blk[t];
      else w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + kk[t] + w[t];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    o = {hh, g, f, e, d, c, b, a};
    for (int i = 0; i < 8; i++) o[i] = o[i] + h[i];
    return o;
  endfunction

  logic [15:0][31:0] msg_blk [4];
  logic [15:0][31:0] abc_blk, nist1, nist2;

  task automatic build_vectors();
    logic [31:0] n1 [16] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                             32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                             32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                             32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    abc_blk = '0; abc_blk[0] = 32'h61626380; abc_blk[15] = 32'h00000018;
    for (int i = 0; i < 16; i++) nist1[i] = n1[i];
    nist2 = '0; nist2[15] = 32'h000001c0;
  endtask

  // Runs one message of nblk blocks from msg_blk; gap idles before the last
  // block, tog wiggles start while the last block is computing.
  task automatic send_msg(input int d, input bit ivs, input logic [7:0][31:0] iv,
                          input int nblk, input int gap, input bit tog,
                          output logic [255:0] dig, output int lat);
    int since = 0, exp_rdy, pulses;
    bit rdy_seen = 1'b0;
    @(negedge clk);
    start_s[d] = 1'b1; iv_sel_s[d] = ivs; iv_in_s[d] = iv;
    @(negedge clk);
    start_s[d] = 1'b0; iv_sel_s[d] = ~ivs; iv_in_s[d] = ~iv;
    for (int b = 0; b < nblk; b++) begin
      if (b > 0) repeat (b == nblk - 1 ? gap : 0) begin @(negedge clk); since++; end
      blk_valid_s[d] = 1'b1; blk_data_s[d] = msg_blk[b]; blk_last_s[d] = (b == nblk - 1);
      while (!blk_ready_w[d] && since < 400) begin @(negedge clk); since++; end
      if (b > 0) begin
        exp_rdy = 64 / RS[d] + 2;
        if (b == nblk - 1 && gap + 1 > exp_rdy) exp_rdy = gap + 1;
        chk($sformatf("ready_lat R%0d", RS[d]), since, exp_rdy);
      end
      @(negedge clk);
      since = 1;
      blk_valid_s[d] = 1'b0; blk_data_s[d] = {16{$urandom}}; blk_last_s[d] = $urandom;
    end
    lat = 1;
    while (!result_valid_w[d] && lat < 300) begin
      if (blk_ready_w[d]) rdy_seen = 1'b1;
      start_s[d] = tog && lat < 64 / RS[d] ? lat[0] : 1'b0;
      @(negedge clk);
      lat++;
    end
    start_s[d] = 1'b0;
    dig = result_w[d];
    chk($sformatf("ready_in_compute R%0d", RS[d]), rdy_seen, 1'b0);
    chk($sformatf("busy_at_rv R%0d", RS[d]), busy_w[d], 1'b0);
    pulses = 0;
    repeat (3) begin @(negedge clk); if (result_valid_w[d]) pulses++; end
    chk($sformatf("rv_pulse R%0d", RS[d]), pulses, 0);
    chk($sformatf("result_hold R%0d", RS[d]), result_w[d], dig);
    chk($sformatf("idle_after R%0d", RS[d]), busy_w[d], 1'b0);
  endtask

  initial begin
    logic [255:0] dig, exp;
    logic [7:0][31:0] mid, iv;
    int lat, nb, pulses;
    bit ivs;
    build_constants();
    build_vectors();
    for (int d = 0; d < NI; d++) begin
      reset_s[d] = 1'b1; start_s[d] = 1'b0; iv_sel_s[d] = 1'b0; iv_in_s[d] = '0;
      blk_valid_s[d] = 1'b0; blk_data_s[d] = '0; blk_last_s[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < NI; d++) begin
      chk("rst_ready", blk_ready_w[d], 1'b0);
      chk("rst_rv", result_valid_w[d], 1'b0);
      chk("rst_busy", busy_w[d], 1'b0);
      chk("rst_result", result_w[d], '0);
      reset_s[d] = 1'b0;
      blk_valid_s[d] = 1'b1; blk_last_s[d] = 1'b1;
    end
    repeat (4) @(negedge clk);
    for (int d = 0; d < NI; d++) begin
      chk("idle_ignores_blk", {busy_w[d], blk_ready_w[d]}, 2'b00);
      blk_valid_s[d] = 1'b0;
    end

    for (int d = 0; d < NI; d++) begin
      msg_blk[0] = abc_blk;
      send_msg(d, 1'b0, ~hh0, 1, 0, 1'b0, dig, lat);
      chk($sformatf("abc R%0d", RS[d]), dig, ABC_DIG);
      chk($sformatf("abc_lat R%0d", RS[d]), lat, 64 / RS[d] + 2);

      msg_blk[0] = nist1; msg_blk[1] = nist2;
      send_msg(d, 1'b0, '0, 2, 0, 1'b0, dig, lat);
      chk($sformatf("nist R%0d", RS[d]), dig, NIST_DIG);
      chk($sformatf("nist_lat R%0d", RS[d]), lat, 64 / RS[d] + 2);

      send_msg(d, 1'b0, '0, 2, 10, 1'b1, dig, lat);
      chk($sformatf("nist_bp R%0d", RS[d]), dig, NIST_DIG);

      mid = ref_compress(hh0, nist1);
      msg_blk[0] = nist2;
      send_msg(d, 1'b1, mid, 1, 0, 1'b0, dig, lat);
      chk($sformatf("midstate R%0d", RS[d]), dig, NIST_DIG);

      for (int r = 0; r < 3; r++) begin
        nb  = 1 + int'($urandom_range(0, 2));
        ivs = 1'($urandom);
        for (int i = 0; i < 8; i++) iv[i] = $urandom;
        mid = ivs ? iv : hh0;
        for (int b = 0; b < nb; b++) begin
          for (int i = 0; i < 16; i++) msg_blk[b][i] = $urandom;
          mid = ref_compress(mid, msg_blk[b]);
        end
        exp = mid;
        send_msg(d, ivs, iv, nb, int'($urandom_range(0, 5)), 1'($urandom), dig, lat);
        chk($sformatf("rand%0d R%0d", r, RS[d]), dig, exp);
      end
    end

    // Abort an "abc" run in its 20th COMPUTE cycle.
    @(negedge clk);
    start_s[0] = 1'b1; iv_sel_s[0] = 1'b0;
    @(negedge clk);
    start_s[0] = 1'b0;
    blk_valid_s[0] = 1'b1; blk_data_s[0] = abc_blk; blk_last_s[0] = 1'b1;
    @(negedge clk);
    blk_valid_s[0] = 1'b0;
    repeat (19) @(negedge clk);
    reset_s[0] = 1'b1;
    @(negedge clk);
    reset_s[0] = 1'b0;
    chk("midrst_busy", busy_w[0], 1'b0);
    chk("midrst_result", result_w[0], '0);
    chk("midrst_ready", blk_ready_w[0], 1'b0);
    pulses = 0;
    repeat (80) begin if (result_valid_w[0]) pulses++; @(negedge clk); end
    chk("midrst_no_rv", pulses, 0);
    msg_blk[0] = abc_blk;
    send_msg(0, 1'b0, '0, 1, 0, 1'b0, dig, lat);
    chk("abc_after_rst", dig, ABC_DIG);
    chk("abc_after_rst_lat", lat, 66);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
